// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light phase schedulers.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GREEN = 2'd1,
    ST_YEL   = 2'd2,
    ST_ARED  = 2'd3
  } state_t;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/tlc_rr_pick.sv
// Combinational round-robin picker: first requester after cur, wrapping, cur last.
module tlc_rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] cur,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [W-1:0] w_cand;

  // Walk offsets from farthest (cur itself) to nearest so the nearest requester wins.
  always_comb begin
    valid  = 1'b0;
    idx    = cur;
    w_cand = cur;
    for (int k = N; k >= 1; k--) begin
      w_cand = W'((int'(cur) + k) % N);
      if (req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Timed round-robin phase scheduler with min/max green, yellow, all-red and preemption.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int N_APPR    = 4,
  parameter int TW        = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  localparam int W = $clog2(N_APPR)
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic [N_APPR-1:0]     req,
  input  logic                  emerg,
  input  logic [W-1:0]          emerg_sel,
  output logic [2*N_APPR-1:0]   light,
  output logic [W-1:0]          active_id,
  output logic                  phase_pulse
);

  localparam logic [TW-1:0] MIN_M1  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_M1  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_M1  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] ARED_M1 = TW'(ALL_RED - 1);

  state_t              r_st;
  logic [W-1:0]        r_cur;
  logic [TW-1:0]       r_tmr;
  logic                r_pre;
  logic [2*N_APPR-1:0] r_light;
  logic                r_pulse;

  state_t              w_stNext;
  logic [W-1:0]        w_curNext;
  logic [TW-1:0]       w_tmrNext;
  logic [TW-1:0]       w_tmrInc;
  logic                w_preNext;
  logic                w_pulseNext;
  logic [2*N_APPR-1:0] w_lightNext;
  logic                w_rrValid;
  logic [W-1:0]        w_rrIdx;
  logic                w_pickValid;
  logic [W-1:0]        w_pick;
  logic                w_others;

  tlc_rr_pick #(.N(N_APPR)) u_pick (
    .req   (req),
    .cur   (r_cur),
    .valid (w_rrValid),
    .idx   (w_rrIdx)
  );

  assign w_pickValid = emerg | w_rrValid;
  assign w_pick      = emerg ? emerg_sel : w_rrIdx;
  assign w_others    = |(req & ~(N_APPR'(1) << r_cur));
  assign w_tmrInc    = (r_tmr == {TW{1'b1}}) ? r_tmr : r_tmr + 1'b1;

  // Next-state logic: phase sequencing, timer reloads and preempt latch.
  always_comb begin
    w_stNext    = r_st;
    w_curNext   = r_cur;
    w_tmrNext   = w_tmrInc;
    w_preNext   = r_pre;
    w_pulseNext = FALSE;
    case (r_st)
      ST_IDLE: begin
        w_tmrNext = '0;
        if (w_pickValid) begin
          w_stNext    = ST_GREEN;
          w_curNext   = w_pick;
          w_pulseNext = TRUE;
        end
      end
      ST_GREEN: begin
        if (emerg && (emerg_sel != r_cur)) begin
          w_stNext  = ST_YEL;
          w_tmrNext = '0;
          w_preNext = TRUE;
        end else if (emerg) begin
          w_stNext = ST_GREEN;
        end else if (w_others && (r_tmr >= MIN_M1) &&
                     (!req[r_cur] || (r_tmr >= MAX_M1))) begin
          w_stNext  = ST_YEL;
          w_tmrNext = '0;
        end
      end
      ST_YEL: begin
        if (r_tmr >= YEL_M1) begin
          w_stNext  = ST_ARED;
          w_tmrNext = '0;
        end
      end
      ST_ARED: begin
        if (r_tmr >= ARED_M1) begin
          w_tmrNext = '0;
          if (w_pickValid) begin
            w_stNext    = ST_GREEN;
            w_curNext   = w_pick;
            w_pulseNext = TRUE;
            w_preNext   = FALSE;
          end else begin
            w_stNext = ST_IDLE;
          end
        end
      end
      default: begin
        w_stNext  = ST_IDLE;
        w_tmrNext = '0;
      end
    endcase
  end

  // Lamp codes derived from the next state so they register on the same edge.
  always_comb begin
    w_lightNext = {N_APPR{LIGHT_RED}};
    if (w_stNext == ST_GREEN) begin
      w_lightNext[int'(w_curNext)*2 +: 2] = LIGHT_GREEN;
    end else if (w_stNext == ST_YEL) begin
      w_lightNext[int'(w_curNext)*2 +: 2] = LIGHT_YELLOW;
    end
  end

  // State, timer and registered outputs; reset drops straight to all-red.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_st    <= ST_IDLE;
      r_cur   <= '0;
      r_tmr   <= '0;
      r_pre   <= FALSE;
      r_light <= {N_APPR{LIGHT_RED}};
      r_pulse <= FALSE;
    end else begin
      r_st    <= w_stNext;
      r_cur   <= w_curNext;
      r_tmr   <= w_tmrNext;
      r_pre   <= w_preNext;
      r_light <= w_lightNext;
      r_pulse <= w_pulseNext;
    end
  end

  assign light       = r_light;
  assign active_id   = r_cur;
  assign phase_pulse = r_pulse;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed self-checking bench for tlc_phase_scheduler (default parameters).
module tb_tlc_phase_scheduler;

  logic       clk;
  logic       clear_n;
  logic [3:0] req;
  logic       emerg;
  logic [1:0] emerg_sel;
  logic [7:0] light;
  logic [1:0] active_id;
  logic       phase_pulse;

  int checks;
  int failures;

  tlc_phase_scheduler dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .req         (req),
    .emerg       (emerg),
    .emerg_sel   (emerg_sel),
    .light       (light),
    .active_id   (active_id),
    .phase_pulse (phase_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clear_n   = 1'b0;
    req       = 4'b0000;
    emerg     = 1'b0;
    emerg_sel = 2'd0;
    tick();
    tick();
    clear_n = 1'b1;
  endtask

  // Counts consecutive sampled cycles on which light equals val (bounded).
  task automatic measureRun(input logic [7:0] val, output int n);
    n = 0;
    while (light === val && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    clear_n   = 1'b0;
    req       = 4'b0000;
    emerg     = 1'b0;
    emerg_sel = 2'd0;
    tick();
    tick();
    checks++;
    if (light !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_light: got %h expected %h", light, 8'h00);
    end
    checks++;
    if (active_id !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_active: got %0d expected %0d", active_id, 0);
    end
    checks++;
    if (phase_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_pulse: got %b expected %b", phase_pulse, 1'b0);
    end
    clear_n = 1'b1;
    tick();
    checks++;
    if (light !== 8'h00 || active_id !== 2'd0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got light=%h id=%0d expected light=00 id=0", light, active_id);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (light !== 8'h02) begin
      failures++;
      $display("[TB] FAIL green0_before_async: got %h expected %h", light, 8'h02);
    end
    #2;
    clear_n = 1'b0;
    #1;
    checks++;
    if (light !== 8'h00) begin
      failures++;
      $display("[TB] FAIL async_reset_light: got %h expected %h", light, 8'h00);
    end
    tick();
    clear_n = 1'b1;
  endtask

  task automatic test_single_request();
    int bad;
    doReset();
    req = 4'b0100;
    tick();
    checks++;
    if (light !== 8'h20 || active_id !== 2'd2) begin
      failures++;
      $display("[TB] FAIL single_green: got light=%h id=%0d expected light=20 id=2", light, active_id);
    end
    checks++;
    if (phase_pulse !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_pulse: got %b expected %b", phase_pulse, 1'b1);
    end
    tick();
    checks++;
    if (phase_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pulse_one_cycle: got %b expected %b", phase_pulse, 1'b0);
    end
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (light !== 8'h20 || phase_pulse !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL green_hold: got %0d bad cycles expected %0d", bad, 0);
    end
  endtask

  task automatic test_max_green();
    int n;
    doReset();
    req = 4'b0001;
    tick();
    req = 4'b0101;
    measureRun(8'h02, n);
    checks++;
    if (n != 16) begin
      failures++;
      $display("[TB] FAIL max_green_len: got %0d expected %0d", n, 16);
    end
    measureRun(8'h01, n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("[TB] FAIL max_yellow_len: got %0d expected %0d", n, 3);
    end
    measureRun(8'h00, n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("[TB] FAIL max_allred_len: got %0d expected %0d", n, 2);
    end
    checks++;
    if (light !== 8'h20 || active_id !== 2'd2 || phase_pulse !== 1'b1) begin
      failures++;
      $display("[TB] FAIL max_next_green: got light=%h id=%0d pulse=%b expected light=20 id=2 pulse=1",
               light, active_id, phase_pulse);
    end
  endtask

  task automatic test_min_green();
    int n;
    doReset();
    req = 4'b0010;
    tick();
    tick();
    req = 4'b1000;
    measureRun(8'h08, n);
    checks++;
    if (n + 1 != 4) begin
      failures++;
      $display("[TB] FAIL min_green_len: got %0d expected %0d", n + 1, 4);
    end
    checks++;
    if (light !== 8'h04 || active_id !== 2'd1) begin
      failures++;
      $display("[TB] FAIL min_yellow: got light=%h id=%0d expected light=04 id=1", light, active_id);
    end
    measureRun(8'h04, n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("[TB] FAIL min_yellow_len: got %0d expected %0d", n, 3);
    end
    measureRun(8'h00, n);
    checks++;
    if (light !== 8'h80 || active_id !== 2'd3 || n != 2) begin
      failures++;
      $display("[TB] FAIL min_handover: got light=%h id=%0d red=%0d expected light=80 id=3 red=2",
               light, active_id, n);
    end
  endtask

  task automatic test_emergency();
    int n;
    int bad;
    doReset();
    req = 4'b0001;
    tick();
    tick();
    emerg     = 1'b1;
    emerg_sel = 2'd2;
    req       = 4'b1011;
    tick();
    checks++;
    if (light !== 8'h01) begin
      failures++;
      $display("[TB] FAIL emerg_yellow_now: got %h expected %h", light, 8'h01);
    end
    measureRun(8'h01, n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("[TB] FAIL emerg_yellow_len: got %0d expected %0d", n, 3);
    end
    measureRun(8'h00, n);
    checks++;
    if (n != 2 || light !== 8'h20 || active_id !== 2'd2) begin
      failures++;
      $display("[TB] FAIL emerg_green: got light=%h id=%0d red=%0d expected light=20 id=2 red=2",
               light, active_id, n);
    end
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (light !== 8'h20) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL emerg_hold: got %0d bad cycles expected %0d", bad, 0);
    end
    emerg = 1'b0;
    tick();
    checks++;
    if (light !== 8'h10) begin
      failures++;
      $display("[TB] FAIL emerg_release: got %h expected %h", light, 8'h10);
    end
  endtask

  task automatic test_fairness();
    int expId;
    int greens;
    int invBad;
    int nonRed;
    logic [1:0] code;
    doReset();
    req    = 4'b1111;
    expId  = 1;
    greens = 0;
    invBad = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      nonRed = 0;
      for (int a = 0; a < 4; a++) begin
        code = light[2*a +: 2];
        if (code === 2'b11) invBad++;
        if (code !== 2'b00) nonRed++;
      end
      if (nonRed > 1) invBad++;
      if (phase_pulse === 1'b1) begin
        greens++;
        checks++;
        if (active_id !== 2'(expId)) begin
          failures++;
          $display("[TB] FAIL fair_order: got %0d expected %0d", active_id, expId);
        end
        expId = (expId + 1) % 4;
      end
    end
    checks++;
    if (greens != 10) begin
      failures++;
      $display("[TB] FAIL fair_green_count: got %0d expected %0d", greens, 10);
    end
    checks++;
    if (invBad != 0) begin
      failures++;
      $display("[TB] FAIL fair_invariant: got %0d violations expected %0d", invBad, 0);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clear_n   = 1'b0;
    req       = 4'b0000;
    emerg     = 1'b0;
    emerg_sel = 2'd0;
    test_reset();
    test_single_request();
    test_max_green();
    test_min_green();
    test_emergency();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
